// File: rtl/tamsayi_carpma_hakemi_if.sv
// Bundle of the requester, multiply-unit and response channels used by the arbiter.
// The arbiter takes the master view; the requesters, unit and consumer take the slave view.
interface tamsayi_carpma_hakemi_if;
    logic        istek0_g;
    logic [3:0]  islev0_g;
    logic [31:0] a0_g;
    logic [31:0] b0_g;
    logic        kabul0_c;

    logic        istek1_g;
    logic [3:0]  islev1_g;
    logic [31:0] a1_g;
    logic [31:0] b1_g;
    logic        kabul1_c;

    logic        carp_hazir_c;
    logic [3:0]  carp_islev_c;
    logic [31:0] carp_a_c;
    logic [31:0] carp_b_c;
    logic        carp_bitti_g;
    logic [31:0] carp_sonuc_g;

    logic        sonuc_gecerli_c;
    logic [31:0] sonuc_c;
    logic        sonuc_id_c;
    logic        sonuc_hata_c;
    logic        yanit_hazir_g;
    logic        mesgul_c;

    modport master (
        input  istek0_g, islev0_g, a0_g, b0_g,
        output kabul0_c,
        input  istek1_g, islev1_g, a1_g, b1_g,
        output kabul1_c,
        output carp_hazir_c, carp_islev_c, carp_a_c, carp_b_c,
        input  carp_bitti_g, carp_sonuc_g,
        output sonuc_gecerli_c, sonuc_c, sonuc_id_c, sonuc_hata_c,
        input  yanit_hazir_g,
        output mesgul_c
    );

    modport slave (
        output istek0_g, islev0_g, a0_g, b0_g,
        input  kabul0_c,
        output istek1_g, islev1_g, a1_g, b1_g,
        input  kabul1_c,
        input  carp_hazir_c, carp_islev_c, carp_a_c, carp_b_c,
        output carp_bitti_g, carp_sonuc_g,
        input  sonuc_gecerli_c, sonuc_c, sonuc_id_c, sonuc_hata_c,
        output yanit_hazir_g,
        input  mesgul_c
    );
endinterface

// File: rtl/tamsayi_carpma_hakemi.sv
// Two-requester round-robin arbiter that sequences one shared integer multiply unit,
// with a done-pulse watchdog and a ready/valid response channel.
module tamsayi_carpma_hakemi #(
    parameter int ZAMAN_ASIMI = 64
) (
    input  logic                    clk_g,
    input  logic                    rst_g,
    tamsayi_carpma_hakemi_if.master arayuz
);
    localparam int SAYAC_G = $clog2(ZAMAN_ASIMI);
    localparam logic [SAYAC_G-1:0] SAYAC_SON = SAYAC_G'(ZAMAN_ASIMI - 1);

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        BASLAT = 2'd1,
        BEKLE  = 2'd2,
        YANIT  = 2'd3
    } durum_t;

    durum_t              durum_reg;
    logic                isaretci_reg;
    logic [3:0]          islev_reg;
    logic [31:0]         a_reg;
    logic [31:0]         b_reg;
    logic                carp_hazir_reg;
    logic [SAYAC_G-1:0]  sayac_reg;
    logic [31:0]         sonuc_reg;
    logic                id_reg;
    logic                hata_reg;
    logic                gecerli_reg;
    logic                mesgul_reg;

    logic [1:0]          istek;
    logic [3:0]          islev [2];
    logic [31:0]         a_in  [2];
    logic [31:0]         b_in  [2];
    logic [1:0]          yasal;
    logic [1:0]          hibe;
    logic                bosta;
    logic                secilen;

    assign istek[0] = arayuz.istek0_g;
    assign istek[1] = arayuz.istek1_g;
    assign islev[0] = arayuz.islev0_g;
    assign islev[1] = arayuz.islev1_g;
    assign a_in[0]  = arayuz.a0_g;
    assign a_in[1]  = arayuz.a1_g;
    assign b_in[0]  = arayuz.b0_g;
    assign b_in[1]  = arayuz.b1_g;

    assign bosta = (durum_reg == BOSTA);

    // A lone requester always wins; on contention the pointer names the winner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_istekci
            assign yasal[gi] = (islev[gi] == 4'h1) || (islev[gi] == 4'h2) ||
                               (islev[gi] == 4'h4) || (islev[gi] == 4'h8);
            assign hibe[gi]  = bosta && istek[gi] &&
                               (!istek[1-gi] || (isaretci_reg == 1'(gi)));
        end
    endgenerate

    assign secilen = hibe[1];

    always_ff @(posedge clk_g) begin
        if (rst_g) begin
            durum_reg      <= BOSTA;
            isaretci_reg   <= 1'b0;
            islev_reg      <= 4'h0;
            a_reg          <= 32'h0;
            b_reg          <= 32'h0;
            carp_hazir_reg <= 1'b0;
            sayac_reg      <= '0;
            sonuc_reg      <= 32'h0;
            id_reg         <= 1'b0;
            hata_reg       <= 1'b0;
            gecerli_reg    <= 1'b0;
            mesgul_reg     <= 1'b0;
        end else begin
            case (durum_reg)
                BOSTA: begin
                    if (|hibe) begin
                        isaretci_reg <= ~secilen;
                        islev_reg    <= islev[secilen];
                        a_reg        <= a_in[secilen];
                        b_reg        <= b_in[secilen];
                        id_reg       <= secilen;
                        mesgul_reg   <= 1'b1;
                        if (yasal[secilen]) begin
                            carp_hazir_reg <= 1'b1;
                            durum_reg      <= BASLAT;
                        end else begin
                            // Illegal codes answer straight away and never touch the unit.
                            sonuc_reg   <= 32'h0;
                            hata_reg    <= 1'b1;
                            gecerli_reg <= 1'b1;
                            durum_reg   <= YANIT;
                        end
                    end
                end
                BASLAT: begin
                    carp_hazir_reg <= 1'b0;
                    sayac_reg      <= '0;
                    durum_reg      <= BEKLE;
                end
                BEKLE: begin
                    sayac_reg <= sayac_reg + 1'b1;
                    // Done is checked first so a pulse in the last watchdog cycle still counts.
                    if (arayuz.carp_bitti_g) begin
                        sonuc_reg   <= arayuz.carp_sonuc_g;
                        hata_reg    <= 1'b0;
                        gecerli_reg <= 1'b1;
                        durum_reg   <= YANIT;
                    end else if (sayac_reg == SAYAC_SON) begin
                        sonuc_reg   <= 32'h0;
                        hata_reg    <= 1'b1;
                        gecerli_reg <= 1'b1;
                        durum_reg   <= YANIT;
                    end
                end
                YANIT: begin
                    if (arayuz.yanit_hazir_g) begin
                        gecerli_reg <= 1'b0;
                        mesgul_reg  <= 1'b0;
                        durum_reg   <= BOSTA;
                    end
                end
                default: begin
                    durum_reg <= BOSTA;
                end
            endcase
        end
    end

    assign arayuz.kabul0_c        = hibe[0];
    assign arayuz.kabul1_c        = hibe[1];
    assign arayuz.carp_hazir_c    = carp_hazir_reg;
    assign arayuz.carp_islev_c    = islev_reg;
    assign arayuz.carp_a_c        = a_reg;
    assign arayuz.carp_b_c        = b_reg;
    assign arayuz.sonuc_gecerli_c = gecerli_reg;
    assign arayuz.sonuc_c         = sonuc_reg;
    assign arayuz.sonuc_id_c      = id_reg;
    assign arayuz.sonuc_hata_c    = hata_reg;
    assign arayuz.mesgul_c        = mesgul_reg;
endmodule

// File: tb/tb_tamsayi_carpma_hakemi.sv
// Scoreboard bench for the multiply arbiter: requester drivers, a multiply unit model
// and a response monitor checked against an arithmetic reference.
module tb_tamsayi_carpma_hakemi;
    localparam int ZA = 24;

    logic clk_g = 1'b0;
    logic rst_g;

    tamsayi_carpma_hakemi_if ifc();

    tamsayi_carpma_hakemi #(.ZAMAN_ASIMI(ZA)) dut (
        .clk_g (clk_g),
        .rst_g (rst_g),
        .arayuz(ifc)
    );

    always #5 clk_g = ~clk_g;

    typedef struct {
        logic [3:0]  islev;
        logic [31:0] a;
        logic [31:0] b;
    } istek_t;

    typedef struct {
        logic        id;
        logic        hata;
        logic [31:0] sonuc;
        int          yukselis;
    } yanit_t;

    istek_t bekleyen0[$];
    istek_t bekleyen1[$];
    yanit_t sb_q[$];
    int     gecikme_q[$];

    int kontrol = 0;
    int hatalar = 0;
    int cyc = 0;
    int son_el_cyc = -1;
    bit sessiz = 1'b0;
    int sabit_gecikme = 0;
    int kacak_sayisi = 0;

    always @(posedge clk_g) cyc <= cyc + 1;

    // Reference multiply: sign/zero-extend to 64 bits, take the product modulo 2^64.
    function automatic logic [31:0] ref_carp(input logic [3:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ua, ub, sa, sbb, p;
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sa  = {{32{a[31]}}, a};
        sbb = {{32{b[31]}}, b};
        p   = 64'h0;
        case (f)
            4'h1: begin p = ua * ub;  return p[31:0];  end
            4'h2: begin p = sa * sbb; return p[63:32]; end
            4'h4: begin p = ua * ub;  return p[63:32]; end
            4'h8: begin p = sa * ub;  return p[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic kontrol_et(input string ad, input logic [31:0] gercek,
                              input logic [31:0] beklenen);
        kontrol++;
        if (gercek !== beklenen) begin
            hatalar++;
            $display("FAIL %s: gercek=%h beklenen=%h (cyc %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    task automatic ekle(input bit id, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b);
        istek_t t;
        t.islev = f;
        t.a     = a;
        t.b     = b;
        if (id) bekleyen1.push_back(t);
        else    bekleyen0.push_back(t);
    endtask

    // Requester driver: predicts the round-robin winner and queues the expected response.
    initial begin : surucu
        bit     bp, bekl_hazir, bos, w, yasal;
        istek_t verilen;
        yanit_t oge;
        int     d;
        bp = 1'b0;
        bekl_hazir = 1'b0;
        verilen.islev = 4'h0;
        verilen.a = 32'h0;
        verilen.b = 32'h0;
        ifc.istek0_g = 1'b0; ifc.islev0_g = 4'h0; ifc.a0_g = 32'h0; ifc.b0_g = 32'h0;
        ifc.istek1_g = 1'b0; ifc.islev1_g = 4'h0; ifc.a1_g = 32'h0; ifc.b1_g = 32'h0;
        forever begin
            @(posedge clk_g); #1;
            ifc.istek0_g = (bekleyen0.size() > 0);
            if (bekleyen0.size() > 0) begin
                ifc.islev0_g = bekleyen0[0].islev; ifc.a0_g = bekleyen0[0].a; ifc.b0_g = bekleyen0[0].b;
            end
            ifc.istek1_g = (bekleyen1.size() > 0);
            if (bekleyen1.size() > 0) begin
                ifc.islev1_g = bekleyen1[0].islev; ifc.a1_g = bekleyen1[0].a; ifc.b1_g = bekleyen1[0].b;
            end
            @(negedge clk_g); #1;
            if (rst_g) begin
                bp = 1'b0;
                bekl_hazir = 1'b0;
            end else begin
                if (ifc.carp_hazir_c || bekl_hazir) begin
                    kontrol_et("carp_hazir", 32'(ifc.carp_hazir_c), 32'(bekl_hazir));
                    if (bekl_hazir) begin
                        kontrol_et("carp_islev", 32'(ifc.carp_islev_c), 32'(verilen.islev));
                        kontrol_et("carp_a", ifc.carp_a_c, verilen.a);
                        kontrol_et("carp_b", ifc.carp_b_c, verilen.b);
                    end
                end
                bekl_hazir = 1'b0;
                bos = (sb_q.size() == 0) && (son_el_cyc < cyc);
                kontrol_et("mesgul", 32'(ifc.mesgul_c), 32'(!bos));
                if (bos && (ifc.istek0_g || ifc.istek1_g)) begin
                    w = (ifc.istek0_g && ifc.istek1_g) ? bp : !ifc.istek0_g;
                    kontrol_et("kabul0", 32'(ifc.kabul0_c), 32'(w == 1'b0));
                    kontrol_et("kabul1", 32'(ifc.kabul1_c), 32'(w == 1'b1));
                    bp = !w;
                    if (w && bekleyen1.size() > 0)       verilen = bekleyen1.pop_front();
                    else if (!w && bekleyen0.size() > 0) verilen = bekleyen0.pop_front();
                    yasal = verilen.islev inside {4'h1, 4'h2, 4'h4, 4'h8};
                    oge.id    = w;
                    oge.hata  = !yasal || sessiz;
                    oge.sonuc = oge.hata ? 32'h0 : ref_carp(verilen.islev, verilen.a, verilen.b);
                    if (!yasal) begin
                        oge.yukselis = cyc + 1;
                    end else if (sessiz) begin
                        oge.yukselis = cyc + ZA + 2;
                    end else begin
                        d = (sabit_gecikme > 0) ? sabit_gecikme : int'($urandom_range(1, ZA));
                        gecikme_q.push_back(d);
                        oge.yukselis = cyc + 2 + d;
                    end
                    bekl_hazir = yasal;
                    sb_q.push_back(oge);
                end else if (ifc.kabul0_c || ifc.kabul1_c) begin
                    kontrol_et("kabul_yok", 32'({ifc.kabul1_c, ifc.kabul0_c}), 32'h0);
                end
            end
        end
    end

    // Multiply unit model: answers d cycles after the start pulse, or stays silent.
    initial begin : birim
        int          kalan;
        int          kacak_gorulen;
        logic [31:0] bekleyen_sonuc;
        kalan = 0;
        kacak_gorulen = 0;
        bekleyen_sonuc = 32'h0;
        ifc.carp_bitti_g = 1'b0;
        ifc.carp_sonuc_g = 32'h0;
        forever begin
            @(negedge clk_g);
            ifc.carp_bitti_g = 1'b0;
            if (rst_g) begin
                kalan = 0;
            end else begin
                if (kalan == 1) begin
                    ifc.carp_bitti_g = 1'b1;
                    ifc.carp_sonuc_g = bekleyen_sonuc;
                end
                if (kalan > 0) kalan--;
                if (kacak_sayisi != kacak_gorulen) begin
                    kacak_gorulen++;
                    ifc.carp_bitti_g = 1'b1;
                    ifc.carp_sonuc_g = 32'hDEADBEEF;
                end
                if (ifc.carp_hazir_c && gecikme_q.size() > 0) begin
                    kalan = gecikme_q.pop_front();
                    bekleyen_sonuc = ref_carp(ifc.carp_islev_c, ifc.carp_a_c, ifc.carp_b_c);
                end
            end
        end
    end

    // Response monitor: checks timing of the rising valid and holds values while stalled.
    initial begin : izleyici
        bit     onceki;
        yanit_t bas;
        onceki = 1'b0;
        forever begin
            @(negedge clk_g);
            if (rst_g) begin
                onceki = 1'b0;
                continue;
            end
            if (ifc.sonuc_gecerli_c) begin
                if (sb_q.size() == 0) begin
                    if (!onceki) begin
                        kontrol++;
                        hatalar++;
                        $display("FAIL beklenmeyen_yanit: gercek sonuc=%h id=%0d beklenen=yanit yok",
                                 ifc.sonuc_c, ifc.sonuc_id_c);
                    end
                end else begin
                    bas = sb_q[0];
                    if (!onceki) kontrol_et("yanit_zamani", cyc, bas.yukselis);
                    kontrol_et("sonuc", ifc.sonuc_c, bas.sonuc);
                    kontrol_et("sonuc_id", 32'(ifc.sonuc_id_c), 32'(bas.id));
                    kontrol_et("sonuc_hata", 32'(ifc.sonuc_hata_c), 32'(bas.hata));
                    if (ifc.yanit_hazir_g) begin
                        void'(sb_q.pop_front());
                        son_el_cyc = cyc;
                        $display("YANIT cyc=%0d id=%0d hata=%0d sonuc=%h", cyc,
                                 ifc.sonuc_id_c, ifc.sonuc_hata_c, ifc.sonuc_c);
                    end
                end
            end
            onceki = ifc.sonuc_gecerli_c;
        end
    end

    task automatic sifirla();
        @(posedge clk_g); #1;
        rst_g = 1'b1;
        repeat (2) @(posedge clk_g);
        #1;
        rst_g = 1'b0;
        sb_q.delete();
        gecikme_q.delete();
    endtask

    task automatic bosalt(input bit rastgele, input int butce);
        int n;
        n = 0;
        forever begin
            @(posedge clk_g); #1;
            ifc.yanit_hazir_g = rastgele ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk_g); #2;
            if (bekleyen0.size() == 0 && bekleyen1.size() == 0 && sb_q.size() == 0 && !ifc.mesgul_c)
                break;
            n++;
            if (n > butce) begin
                kontrol++;
                hatalar++;
                $display("FAIL bosaltma_suresi: gercek kalan=%0d beklenen=0", sb_q.size());
                sb_q.delete();
                bekleyen0.delete();
                bekleyen1.delete();
                break;
            end
        end
        gecikme_q.delete();
    endtask

    task automatic hepsi_sifir(input string ad);
        kontrol_et({ad, "_kabul0"}, 32'(ifc.kabul0_c), 32'h0);
        kontrol_et({ad, "_kabul1"}, 32'(ifc.kabul1_c), 32'h0);
        kontrol_et({ad, "_carp_hazir"}, 32'(ifc.carp_hazir_c), 32'h0);
        kontrol_et({ad, "_carp_islev"}, 32'(ifc.carp_islev_c), 32'h0);
        kontrol_et({ad, "_carp_a"}, ifc.carp_a_c, 32'h0);
        kontrol_et({ad, "_carp_b"}, ifc.carp_b_c, 32'h0);
        kontrol_et({ad, "_gecerli"}, 32'(ifc.sonuc_gecerli_c), 32'h0);
        kontrol_et({ad, "_sonuc"}, ifc.sonuc_c, 32'h0);
        kontrol_et({ad, "_id"}, 32'(ifc.sonuc_id_c), 32'h0);
        kontrol_et({ad, "_hata"}, 32'(ifc.sonuc_hata_c), 32'h0);
        kontrol_et({ad, "_mesgul"}, 32'(ifc.mesgul_c), 32'h0);
    endtask

    initial begin : ana
        int          n;
        logic [3:0]  f;
        logic [31:0] ra, rb;
        rst_g = 1'b1;
        ifc.yanit_hazir_g = 1'b1;
        repeat (3) @(posedge clk_g);
        #1;
        rst_g = 1'b0;
        @(negedge clk_g); #2;
        hepsi_sifir("reset");

        // Single MUL with a 17-cycle unit
        sabit_gecikme = 17;
        ekle(1'b0, 4'h1, 32'd7, 32'hFFFFFFFD);
        bosalt(1'b0, 200);

        // Contention straight after reset, then alternation with both held
        sifirla();
        sabit_gecikme = 0;
        @(negedge clk_g); #2;
        ekle(1'b0, 4'h4, 32'hFFFFFFFF, 32'hFFFFFFFF);
        ekle(1'b1, 4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 2; i++) begin
            ekle(1'b0, 4'h1, $urandom, $urandom);
            ekle(1'b1, 4'h8, $urandom, $urandom);
        end
        bosalt(1'b0, 600);

        // Illegal code, then MULHSU
        ekle(1'b1, 4'h3, 32'h12345678, 32'h9ABCDEF0);
        ekle(1'b1, 4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bosalt(1'b0, 200);

        // Silent unit: watchdog, then a stray done in idle
        sessiz = 1'b1;
        ekle(1'b0, 4'h1, 32'd5, 32'd6);
        bosalt(1'b0, 200);
        sessiz = 1'b0;
        kacak_sayisi++;
        repeat (3) @(negedge clk_g);
        #2;
        kontrol_et("kacak_gecerli", 32'(ifc.sonuc_gecerli_c), 32'h0);
        kontrol_et("kacak_sonuc", ifc.sonuc_c, 32'h0);
        kontrol_et("kacak_hata", 32'(ifc.sonuc_hata_c), 32'h1);
        kontrol_et("kacak_mesgul", 32'(ifc.mesgul_c), 32'h0);

        // Backpressure with a pending request behind the stalled response
        sabit_gecikme = 4;
        @(posedge clk_g); #1;
        ifc.yanit_hazir_g = 1'b0;
        ekle(1'b0, 4'h1, 32'd9, 32'd9);
        n = 0;
        do begin
            @(negedge clk_g); #2;
            n++;
        end while (!ifc.sonuc_gecerli_c && n < 100);
        kontrol_et("geri_basinc_gecerli", 32'(ifc.sonuc_gecerli_c), 32'h1);
        ekle(1'b0, 4'h2, $urandom, $urandom);
        repeat (5) @(posedge clk_g);
        bosalt(1'b0, 200);

        // Reset while waiting for the unit
        sabit_gecikme = 20;
        ekle(1'b0, 4'h1, 32'd11, 32'd13);
        n = 0;
        do begin
            @(negedge clk_g); #2;
            n++;
        end while (!ifc.carp_hazir_c && n < 100);
        kontrol_et("rst_oncesi_baslat", 32'(ifc.carp_hazir_c), 32'h1);
        repeat (3) @(posedge clk_g);
        #1;
        rst_g = 1'b1;
        @(posedge clk_g); #1;
        rst_g = 1'b0;
        sb_q.delete();
        gecikme_q.delete();
        @(negedge clk_g); #2;
        hepsi_sifir("ara_reset");
        sabit_gecikme = 5;
        ekle(1'b0, 4'h1, 32'd3, 32'd4);
        bosalt(1'b0, 200);

        // Randomized traffic with random backpressure
        sabit_gecikme = 0;
        for (int i = 0; i < 40; i++) begin
            f  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            ra = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
            ekle(1'($urandom), f, ra, rb);
        end
        bosalt(1'b1, 5000);

        $display("CHECKS %0d ERRORS %0d", kontrol, hatalar);
        $finish;
    end

    initial begin : bekci
        #500000;
        $display("FAIL genel_sure: gercek=sure doldu beklenen=bitis");
        $fatal(1);
    end
endmodule
